// File: rtl/ecc_fifo_rd_decode.sv
// Read-side SECDED check/correct for the ECC FIFO: stage 1 computes the syndrome,
// stage 2 classifies and corrects. Both stages use valid/ready, and status counters saturate.
module ecc_fifo_rd_decode #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [6:0]       in_ecc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_sec,
   output logic             out_ded,
   output logic [5:0]       out_syndrome,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] sec_cnt,
   output logic [CNT_W-1:0] ded_cnt,
   output logic             err_sticky
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Codeword position of data bit idx: the idx-th non-power-of-2 position in 1..38.
   function automatic logic [5:0] data_pos(input int idx);
      int         n;
      logic [5:0] pos;
      n   = 0;
      pos = '0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == idx) pos = 6'(p);
            n++;
         end
      end
      return pos;
   endfunction

   logic        s1_valid;
   logic [31:0] s1_data;
   logic [5:0]  s1_syn;
   logic        s1_ov;

   logic [5:0]  syn_c;
   logic        ov_c;
   logic [31:0] dec_data;
   logic        dec_sec;
   logic        dec_ded;

   logic        out_adv;
   logic        s1_load;
   logic        s2_load;
   logic        xfer;

   assign out_adv  = !out_valid || out_ready;
   assign in_ready = !s1_valid || out_adv;
   assign s1_load  = in_valid && in_ready;
   assign s2_load  = s1_valid && out_adv;
   assign xfer     = out_valid && out_ready;

   // A set bit at position p contributes p to the syndrome; parity bit p[k] sits at 2^k.
   always_comb begin
      syn_c = '0;
      ov_c  = in_ecc[0];
      for (int i = 0; i < 32; i++) begin
         if (in_data[i]) syn_c = syn_c ^ data_pos(i);
         ov_c = ov_c ^ in_data[i];
      end
      for (int k = 0; k < 6; k++) begin
         syn_c[k] = syn_c[k] ^ in_ecc[k+1];
         ov_c     = ov_c ^ in_ecc[k+1];
      end
   end

   // A power-of-2 syndrome or zero never matches a data position, so the data is left unchanged.
   always_comb begin
      dec_data = s1_data;
      dec_sec  = 1'b0;
      dec_ded  = 1'b0;
      if (s1_ov) begin
         if (s1_syn <= 6'd38) begin
            dec_sec = 1'b1;
            for (int i = 0; i < 32; i++) begin
               if (data_pos(i) == s1_syn) dec_data[i] = ~s1_data[i];
            end
         end else begin
            dec_ded = 1'b1;
         end
      end else if (s1_syn != 6'd0) begin
         dec_ded = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_ov    <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_syn   <= syn_c;
            s1_ov    <= ov_c;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sec      <= 1'b0;
         out_ded      <= 1'b0;
         out_syndrome <= '0;
      end else begin
         if (s2_load) begin
            out_valid    <= 1'b1;
            out_data     <= dec_data;
            out_sec      <= dec_sec;
            out_ded      <= dec_ded;
            out_syndrome <= s1_syn;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

   // A clear wins over a same-cycle increment; that event is dropped.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         sec_cnt    <= '0;
         ded_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (xfer) begin
         if (out_sec && sec_cnt != CNT_MAX) sec_cnt <= sec_cnt + 1'b1;
         if (out_ded && ded_cnt != CNT_MAX) ded_cnt <= ded_cnt + 1'b1;
         if (out_sec || out_ded) err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_fifo_rd_decode.sv
// Self-checking bench for ecc_fifo_rd_decode: directed vectors, errors injected into encoded
// random words, and backpressure, saturation, clear and reset sequences.
module tb_ecc_fifo_rd_decode;

   localparam int TB_CNT_W = 8;

   typedef struct packed {
      logic [31:0] data;
      logic        sec;
      logic        ded;
      logic [5:0]  syn;
   } exp_t;

   typedef struct packed {
      logic [31:0] in_data;
      logic [6:0]  in_ecc;
      exp_t        x;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [31:0]         in_data = '0;
   logic [6:0]          in_ecc = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [31:0]         out_data;
   logic                out_sec;
   logic                out_ded;
   logic [5:0]          out_syndrome;
   logic                cnt_clr = 1'b0;
   logic [TB_CNT_W-1:0] sec_cnt;
   logic [TB_CNT_W-1:0] ded_cnt;
   logic                err_sticky;

   ecc_fifo_rd_decode #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ecc(in_ecc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sec(out_sec), .out_ded(out_ded), .out_syndrome(out_syndrome),
      .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_bad = 0;
   bit   chk_en = 0;
   bit   rand_bp = 0;
   exp_t q[$];
   int   dpos[32];
   int   didx[39];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [6:0] encode(input logic [31:0] d);
      logic [5:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) if (d[i]) p = p ^ 6'(dpos[i]);
      return {p, (^d) ^ (^p)};
   endfunction

   function automatic void flip_pos(input int pos, inout logic [31:0] d, inout logic [6:0] e);
      if (pos == 0) e[0] = ~e[0];
      else if (didx[pos] < 0) begin
         for (int k = 0; k < 6; k++) if (pos == (1 << k)) e[k+1] = ~e[k+1];
      end else d[didx[pos]] = ~d[didx[pos]];
   endfunction

   task automatic send(input logic [31:0] d, input logic [6:0] e, input exp_t x);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_ecc   = e;
      acc = 0;
      n   = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) q.push_back(x);
         tick();
         n++;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      in_ecc   = 7'($urandom);
      if (!acc) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected accept");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", q.size());
      end
   endtask

   // Checker and reference counters, evaluated half a cycle before each active edge.
   logic                pv = 0, pr = 0, psec = 0, pded = 0, prst = 1;
   logic [31:0]         pd = '0;
   logic [5:0]          ps = '0;
   logic [TB_CNT_W-1:0] m_sec = '0, m_ded = '0;
   logic                m_sticky = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         bit   xf, got;
         if (!prst && pv && !pr) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pd);
            chk("stall_sec", out_sec, psec);
            chk("stall_ded", out_ded, pded);
            chk("stall_syn", out_syndrome, ps);
         end
         chk("sec_cnt", sec_cnt, m_sec);
         chk("ded_cnt", ded_cnt, m_ded);
         chk("err_sticky", err_sticky, m_sticky);
         xf  = out_valid && out_ready && !rst;
         got = 0;
         e   = '0;
         if (xf) begin
            n_vec++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_word: got data 0x%0h expected no transfer", out_data);
            end else begin
               e   = q.pop_front();
               got = 1;
               chk("out_data", out_data, e.data);
               chk("out_sec", out_sec, e.sec);
               chk("out_ded", out_ded, e.ded);
               chk("out_syndrome", out_syndrome, e.syn);
            end
         end
         if (rst || cnt_clr) begin
            m_sec = '0;
            m_ded = '0;
            m_sticky = 0;
         end else if (got) begin
            if (e.sec && m_sec != '1) m_sec = m_sec + 1'b1;
            if (e.ded && m_ded != '1) m_ded = m_ded + 1'b1;
            if (e.sec || e.ded) m_sticky = 1;
         end
      end
      pv = out_valid; pr = out_ready; pd = out_data; psec = out_sec;
      pded = out_ded; ps = out_syndrome; prst = rst;
   end

   vec_t vt[8];

   initial begin
      int n;
      logic [31:0] d, d0;
      logic [6:0]  ec;
      int          nf, p1, p2;
      exp_t        x;

      n = 0;
      for (int p = 0; p <= 38; p++) didx[p] = -1;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            dpos[n] = p;
            didx[p] = n;
            n++;
         end
      end

      //               in_data        ecc      data           sec   ded   syn
      vt[0] = '{32'h0000_0000, 7'h00, '{32'h0000_0000, 1'b0, 1'b0, 6'd0}};
      vt[1] = '{32'h0000_0001, 7'h00, '{32'h0000_0000, 1'b1, 1'b0, 6'd3}};
      vt[2] = '{32'h0000_0000, 7'h01, '{32'h0000_0000, 1'b1, 1'b0, 6'd0}};
      vt[3] = '{32'h0000_0003, 7'h00, '{32'h0000_0003, 1'b0, 1'b1, 6'd6}};
      vt[4] = '{32'h0000_0001, 7'h48, '{32'h0000_0001, 1'b0, 1'b1, 6'd39}};
      vt[5] = '{32'h0000_0001, 7'h44, '{32'h0400_0001, 1'b1, 1'b0, 6'd33}};
      vt[6] = '{32'h0000_0000, 7'h10, '{32'h0000_0000, 1'b1, 1'b0, 6'd8}};
      vt[7] = '{32'h8000_0000, 7'h00, '{32'h0000_0000, 1'b1, 1'b0, 6'd38}};

      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sec", out_sec, 0);
      chk("rst_out_ded", out_ded, 0);
      chk("rst_syndrome", out_syndrome, 0);
      chk("rst_sec_cnt", sec_cnt, 0);
      chk("rst_ded_cnt", ded_cnt, 0);
      chk("rst_sticky", err_sticky, 0);
      chk_en = 1;
      rst = 1'b0;
      tick();

      // Two-cycle latency on an empty pipe.
      send(32'h0, 7'h0, '{32'h0, 1'b0, 1'b0, 6'd0});
      chk("lat_not_yet", out_valid, 0);
      tick();
      chk("lat_valid", out_valid, 1);
      drain();

      for (int i = 0; i < 8; i++) send(vt[i].in_data, vt[i].in_ecc, vt[i].x);
      drain();

      // Backpressure: both stages fill, in_ready drops, then release.
      out_ready = 1'b0;
      fork
         for (int i = 0; i < 5; i++) begin
            d = 32'h1111_0000 + 32'(i);
            send(d, encode(d), '{d, 1'b0, 1'b0, 6'd0});
         end
         begin
            repeat (4) tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
      join
      drain();

      // Encoded random words with 0, 1 or 2 injected flips under random backpressure.
      rand_bp = 1;
      for (int t = 0; t < 250; t++) begin
         d0 = $urandom;
         d  = d0;
         ec = encode(d0);
         nf = $urandom_range(0, 2);
         p1 = $urandom_range(0, 38);
         p2 = $urandom_range(0, 38);
         while (p2 == p1) p2 = $urandom_range(0, 38);
         if (nf >= 1) flip_pos(p1, d, ec);
         if (nf == 2) flip_pos(p2, d, ec);
         if (nf == 0)      x = '{d0, 1'b0, 1'b0, 6'd0};
         else if (nf == 1) x = '{d0, 1'b1, 1'b0, 6'(p1)};
         else              x = '{d, 1'b0, 1'b1, 6'(p1 ^ p2)};
         send(d, ec, x);
         if ($urandom_range(0, 3) == 0) tick();
      end
      drain();
      rand_bp = 0;
      out_ready = 1'b0;

      // Reset while two words are in flight.
      send(32'h0000_0001, 7'h00, '{32'h0, 1'b1, 1'b0, 6'd3});
      send(32'h0000_0003, 7'h00, '{32'h3, 1'b0, 1'b1, 6'd6});
      rst = 1'b1;
      q.delete();
      tick();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sec_cnt", sec_cnt, 0);
      chk("midrst_ded_cnt", ded_cnt, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_no_word", out_valid, 0);

      // Saturation of the SEC counter.
      for (int t = 0; t < 270; t++) begin
         p1 = $urandom_range(0, 31);
         d  = 32'h1 << p1;
         send(d, 7'h00, '{32'h0, 1'b1, 1'b0, 6'(dpos[p1])});
      end
      drain();
      tick();
      chk("sec_saturated", sec_cnt, 8'hFF);

      // Clear coincident with a SEC transfer.
      out_ready = 1'b0;
      send(32'h0000_0001, 7'h00, '{32'h0, 1'b1, 1'b0, 6'd3});
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk("clr_word_ready", out_valid, 1);
      cnt_clr = 1'b1;
      out_ready = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_sec_cnt", sec_cnt, 0);
      chk("clr_sticky", err_sticky, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
